// File: rtl/registers_if.sv
// registers_if: ALU, register-file and fetch signals between controller and datapath
interface registers_if;
  logic [2:0] opcode;
  logic [7:0] A;
  logic [7:0] B;
  logic [7:0] alu_out;
  logic [1:0] addr;
  logic rd;
  logic wr;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic [7:0] pc;
  logic en;
  logic [15:0] ir_data;
  modport master (
    output opcode, A, B, addr, rd, wr, data_in, pc, en,
    input alu_out, data_out, ir_data
  );
  modport slave (
    input opcode, A, B, addr, rd, wr, data_in, pc, en,
    output alu_out, data_out, ir_data
  );
endinterface

// File: rtl/registers.sv
// registers: combinational ALU, 4x8 register file and ROM-backed instruction register
module registers (
  input logic clk,
  input logic rst,
  registers_if.slave bus
);
  logic [7:0] regs [4];
  logic [15:0] ir_q;
  logic [7:0] alu;
  function automatic logic [15:0] rom(input logic [7:0] a);
    case (a)
      8'd0: rom = 16'h8005;
      8'd1: rom = 16'h8103;
      8'd2: rom = 16'h0201;
      8'd3: rom = 16'h1301;
      8'd4: rom = 16'hF006;
      8'd5: rom = 16'h80FF;
      8'd6: rom = 16'h0023;
      default: rom = 16'hE000;
    endcase
  endfunction
  // ALU: 8-bit wrapping result, no flags, independent of reset
  always_comb begin
    alu = bus.A;
    case (bus.opcode)
      3'b000: alu = bus.A + bus.B;
      3'b001: alu = bus.A - bus.B;
      3'b010: alu = bus.A & bus.B;
      3'b011: alu = bus.A | bus.B;
      3'b100: alu = bus.A ^ bus.B;
      3'b101: alu = ~bus.A;
      3'b110: alu = bus.A << 1;
      default: alu = bus.A;
    endcase
  end
  // register file write; reset wins over wr
  always_ff @(posedge clk) begin
    if (rst) for (int i = 0; i < 4; i++) regs[i] <= 8'h00;
    else if (bus.wr) regs[bus.addr] <= bus.data_in;
  end
  // instruction fetch; reset wins over en, holds when en is low
  always_ff @(posedge clk) begin
    if (rst) ir_q <= 16'h0000;
    else if (bus.en) ir_q <= rom(bus.pc);
  end
  assign bus.alu_out = alu;
  assign bus.data_out = bus.rd ? regs[bus.addr] : 8'h00;
  assign bus.ir_data = ir_q;
endmodule

// File: tb/tb_registers.sv
// tb_registers: scoreboard bench for ALU, register file, fetch and a small program run
module tb_registers;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  registers_if bus();
  registers dut (.clk(clk), .rst(rst), .bus(bus));
  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] exp_q[$];
  string tag_q[$];
  logic [7:0] m_regs [4];
  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic push(input string tag, input logic [15:0] e);
    tag_q.push_back(tag);
    exp_q.push_back(e);
  endtask
  task automatic pop(input logic [15:0] obs);
    if (exp_q.size() > 0) check(tag_q.pop_front(), obs, exp_q.pop_front());
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [15:0] rom_m(input logic [7:0] a);
    return a == 0 ? 16'h8005 : a == 1 ? 16'h8103 : a == 2 ? 16'h0201 :
           a == 3 ? 16'h1301 : a == 4 ? 16'hF006 : a == 5 ? 16'h80FF :
           a == 6 ? 16'h0023 : 16'hE000;
  endfunction
  function automatic logic [7:0] alu_m(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return ~a;
      3'd6: return {a[6:0], 1'b0};
      default: return a;
    endcase
  endfunction
  task automatic rf_write(input logic [1:0] a, input logic [7:0] d);
    bus.addr = a;
    bus.data_in = d;
    bus.wr = 1'b1;
    tick();
    bus.wr = 1'b0;
    m_regs[a] = d;
  endtask
  task automatic rd_check(input string tag, input logic [1:0] a, input logic [7:0] e);
    bus.rd = 1'b1;
    bus.addr = a;
    #1;
    push(tag, {8'h00, e});
    pop({8'h00, bus.data_out});
  endtask
  task automatic alu_check(input string tag, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input logic [7:0] e);
    bus.opcode = op;
    bus.A = a;
    bus.B = b;
    #1;
    push(tag, {8'h00, e});
    pop({8'h00, bus.alu_out});
  endtask
  initial begin
    logic [7:0] pc_i;
    logic [15:0] ir;
    logic [7:0] a_v, b_v;
    logic seen5;
    bus.opcode = 3'd0; bus.A = 8'd0; bus.B = 8'd0; bus.addr = 2'd0;
    bus.rd = 1'b0; bus.wr = 1'b1; bus.data_in = 8'h5A; bus.pc = 8'd3; bus.en = 1'b1;
    rst = 1'b1;
    tick();
    alu_check("alu_in_reset", 3'd0, 8'd200, 8'd100, 8'd44);
    tick();
    rst = 1'b0;
    bus.wr = 1'b0;
    bus.en = 1'b0;
    for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
    push("ir_reset", 16'h0000);
    pop(bus.ir_data);
    for (int i = 0; i < 4; i++) rd_check($sformatf("reset_r%0d", i), 2'(i), 8'h00);
    alu_check("add_wrap", 3'd0, 8'd200, 8'd100, 8'd44);
    alu_check("sub_wrap", 3'd1, 8'd3, 8'd5, 8'd254);
    alu_check("shl_msb", 3'd6, 8'h81, 8'h00, 8'h02);
    alu_check("not_a", 3'd5, 8'h0F, 8'hFF, 8'hF0);
    for (int i = 0; i < 16; i++) begin
      a_v = 8'($urandom);
      b_v = 8'($urandom);
      alu_check($sformatf("alu_op%0d", i % 8), 3'(i), a_v, b_v, alu_m(3'(i), a_v, b_v));
    end
    rf_write(2'd2, 8'hA5);
    rd_check("rf_r2", 2'd2, 8'hA5);
    bus.rd = 1'b0;
    #1;
    push("rd_low", 16'h0000);
    pop({8'h00, bus.data_out});
    for (int i = 0; i < 4; i++) rf_write(2'(i), 8'(8'h11 * (i + 1)));
    for (int i = 0; i < 4; i++) rd_check($sformatf("rf_pat_r%0d", i), 2'(i), m_regs[i]);
    bus.rd = 1'b1; bus.wr = 1'b1; bus.addr = 2'd1; bus.data_in = 8'h77;
    #1;
    push("rdwr_old", 16'h0022);
    pop({8'h00, bus.data_out});
    tick();
    bus.wr = 1'b0;
    m_regs[1] = 8'h77;
    push("rdwr_new", 16'h0077);
    pop({8'h00, bus.data_out});
    bus.en = 1'b1; bus.pc = 8'd4;
    tick();
    push("fetch4", 16'hF006);
    pop(bus.ir_data);
    bus.en = 1'b0; bus.pc = 8'd5;
    tick();
    push("fetch_hold", 16'hF006);
    pop(bus.ir_data);
    bus.en = 1'b1; bus.pc = 8'd200;
    tick();
    push("fetch_nop", 16'hE000);
    pop(bus.ir_data);
    bus.en = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
    pc_i = 8'd0;
    seen5 = 1'b0;
    for (int s = 0; s < 16 && pc_i <= 8'd10; s++) begin
      if (pc_i == 8'd5) seen5 = 1'b1;
      bus.en = 1'b1;
      bus.pc = pc_i;
      push($sformatf("prog_ir%0d", pc_i), rom_m(pc_i));
      tick();
      bus.en = 1'b0;
      pop(bus.ir_data);
      ir = bus.ir_data;
      case (ir[15:12])
        4'b1000: begin
          rf_write(ir[9:8], ir[7:0]);
          pc_i++;
        end
        4'b0000, 4'b0001: begin
          bus.rd = 1'b1;
          bus.addr = ir[5:4];
          #1;
          a_v = bus.data_out;
          bus.addr = ir[1:0];
          #1;
          b_v = bus.data_out;
          bus.rd = 1'b0;
          alu_check("prog_alu", ir[14:12], a_v, b_v, alu_m(ir[14:12], m_regs[ir[5:4]], m_regs[ir[1:0]]));
          rf_write(ir[9:8], bus.alu_out);
          pc_i++;
        end
        4'b1111: pc_i = ir[7:0];
        default: pc_i++;
      endcase
    end
    check("skip_pc5", {15'd0, seen5}, 16'd0);
    rd_check("prog_r0", 2'd0, 8'd10);
    rd_check("prog_r1", 2'd1, 8'd3);
    rd_check("prog_r2", 2'd2, 8'd8);
    rd_check("prog_r3", 2'd3, 8'd2);
    bus.wr = 1'b1; bus.en = 1'b1; bus.addr = 2'd3; bus.data_in = 8'hEE; bus.pc = 8'd6;
    rst = 1'b1;
    tick();
    rst = 1'b0; bus.wr = 1'b0; bus.en = 1'b0;
    push("midrst_ir", 16'h0000);
    pop(bus.ir_data);
    for (int i = 0; i < 4; i++) rd_check($sformatf("midrst_r%0d", i), 2'(i), 8'h00);
    check("sb_drain", 16'(exp_q.size()), 16'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/registers.md
REGISTERS -- requirements
Module: registers

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: synchronous reset, active-high.
REQ-003 SHALL have port opcode, input, 3 bits: ALU operation select.
REQ-004 SHALL have port A, input, 8 bits: ALU operand A.
REQ-005 SHALL have port B, input, 8 bits: ALU operand B.
REQ-006 SHALL have port alu_out, output, 8 bits: ALU result.
REQ-007 SHALL have port addr, input, 2 bits: register-file index R0..R3.
REQ-008 SHALL have port rd, input, 1 bit: read enable.
REQ-009 SHALL have port wr, input, 1 bit: write enable.
REQ-010 SHALL have port data_in, input, 8 bits: write data.
REQ-011 SHALL have port data_out, output, 8 bits: read data.
REQ-012 SHALL have port pc, input, 8 bits: instruction ROM address.
REQ-013 SHALL have port en, input, 1 bit: instruction fetch enable.
REQ-014 SHALL have port ir_data, output, 16 bits: fetched instruction.

Function
REQ-015 ALU SHALL be combinational, 8-bit, wrapping, no carry or flags.
- 000 A+B; 001 A-B; 010 A&B; 011 A|B; 100 A^B; 101 ~A; 110 A<<1; 111 pass A.
REQ-016 Register file SHALL be four 8-bit registers; write on rising clk when wr=1: reg[addr] <= data_in.
REQ-017 data_out SHALL be combinational: reg[addr] when rd=1, else 8'h00.
- rd and wr both 1 on the same addr: data_out shows the old value until the clock edge.
REQ-018 Instruction register SHALL load ROM[pc] into ir_data on rising clk when en=1; it SHALL hold when en=0.
REQ-019 The ROM SHALL be 256x16, read-only, with a fixed program:
- 0: 16'h8005 (LOAD R0,5)
- 1: 16'h8103 (LOAD R1,3)
- 2: 16'h0201 (ADD R2,R0,R1)
- 3: 16'h1301 (SUB R3,R0,R1)
- 4: 16'hF006 (JMP 6)
- 5: 16'h80FF (LOAD R0,255)
- 6: 16'h0023 (ADD R0,R2,R3)
- 7-255: 16'hE000 (NOP)
REQ-020 Instruction encoding SHALL be as follows:
- [15:12] class: 1000 LOAD, 0000 ADD, 0001 SUB, 1111 JMP; any other class is NOP.
- [9:8] destination register; [5:4] source 1; [1:0] source 2.
- [7:0] immediate for LOAD, target address for JMP.
- ALU opcode for ADD/SUB = ir_data[14:12].
REQ-021 No sequencing logic SHALL reside in the block; the external controller drives pc, addr, rd, wr and the ALU operands.

Reset
REQ-022 rst=1 at a rising edge SHALL clear R0..R3 to 8'h00 and ir_data to 16'h0000; rst SHALL override wr and en.
REQ-023 After reset, data_out SHALL read 8'h00 for every addr; alu_out SHALL be unaffected by rst (combinational).

Verification
REQ-024 ALU: A=200, B=100, opcode=000 -> alu_out=44 (wrap); opcode=001, A=3, B=5 -> alu_out=254.
REQ-025 Register file: wr=1, addr=2, data_in=8'hA5, one clock, then rd=1, addr=2 -> data_out=8'hA5; rd=0 -> data_out=8'h00.
REQ-026 Fetch: en=1, pc=4, one clock -> ir_data=16'hF006; then en=0, pc=5, one clock -> ir_data stays 16'hF006.
REQ-027 Program run: a controller executes pc 0..10 with JMP handling -> R0=10, R1=3, R2=8, R3=2; pc 5 is skipped.
REQ-028 Reset mid-operation: after REQ-027 state, rst=1 for one clock with wr=1, en=1 -> all registers 0 and ir_data=16'h0000.
